// File: rtl/mvu_apb_cfg_sequencer_if.sv
// Bus bundles for mvu_apb_cfg_sequencer: the command stream into the sequencer
// and the APB write port out to the MVU array.

// Command handshake: a command transfers on every rising edge where
// cmd_valid && cmd_ready; the producer holds its fields stable until accepted.
interface mvu_cmd_if #(
   parameter int BMVUA = 3,
   parameter int DW    = 32
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [BMVUA-1:0] cmd_mvu_id;
   logic [11:0]      cmd_addr;
   logic [DW-1:0]    cmd_data;

   modport master (output cmd_valid, cmd_mvu_id, cmd_addr, cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, cmd_mvu_id, cmd_addr, cmd_data, output cmd_ready);
endinterface

interface mvu_apb_if #(
   parameter int AW = 15,
   parameter int DW = 32
);
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic          pready;
   logic          pslverr;

   modport master (output psel, penable, pwrite, paddr, pwdata, input pready, pslverr);
   modport slave  (input psel, penable, pwrite, paddr, pwdata, output pready, pslverr);
endinterface

// File: rtl/mvu_apb_cfg_sequencer.sv
// Drains a FIFO of MVU CSR writes onto APB in order, holding back writes to any
// MVU whose job (launched by a COMMAND CSR write) has not yet signalled done.
module mvu_apb_cfg_sequencer #(
   parameter int          NMVU           = 8,
   parameter int          BMVUA          = 3,
   parameter int          APB_ADDR_WIDTH = 15,
   parameter int          APB_DATA_WIDTH = 32,
   parameter int          FIFO_DEPTH     = 8,
   parameter logic [11:0] CMD_CSR_ADDR   = 12'hF20
) (
   input  logic                          clk,
   input  logic                          rst,
   mvu_cmd_if.slave                      cmd,
   mvu_apb_if.master                     apb,
   input  logic [NMVU-1:0]               mvu_irq,
   output logic [NMVU-1:0]               mvu_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          err,
   input  logic                          err_clr,
   output logic [1:0]                    o_dbg_state
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   // Encoding chosen so psel/penable come straight off state flop bits.
   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_SETUP  = 2'b01,
      S_ACCESS = 2'b11
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;

   logic [BMVUA-1:0]          r_fifo_id   [FIFO_DEPTH];
   logic [11:0]               r_fifo_addr [FIFO_DEPTH];
   logic [APB_DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
   logic [PW-1:0]             r_wptr;
   logic [PW-1:0]             r_rptr;
   logic [CW-1:0]             r_count;

   logic [APB_ADDR_WIDTH-1:0] r_paddr;
   logic [APB_DATA_WIDTH-1:0] r_pwdata;
   logic [NMVU-1:0]           r_busy;
   logic                      r_err;

   logic                      w_ready;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_empty;
   logic                      w_launch;
   logic                      w_drop;
   logic                      w_done;
   logic [BMVUA-1:0]          w_head_id;
   logic [11:0]               w_head_addr;
   logic [APB_DATA_WIDTH-1:0] w_head_data;
   logic                      w_head_in_range;
   logic                      w_head_busy;
   logic [BMVUA-1:0]          w_cur_id;
   logic                      w_cur_is_cmd;
   logic [NMVU-1:0]           w_busy_set;
   logic [NMVU-1:0]           w_busy_nxt;

   assign w_ready         = (r_count != CW'(FIFO_DEPTH));
   assign w_push          = cmd.cmd_valid && w_ready;
   assign w_empty         = (r_count == '0);
   assign w_pop           = w_launch || w_drop;
   assign w_done          = (r_state == S_ACCESS) && apb.pready;
   assign w_head_id       = r_fifo_id[r_rptr];
   assign w_head_addr     = r_fifo_addr[r_rptr];
   assign w_head_data     = r_fifo_data[r_rptr];
   assign w_head_in_range = (32'(w_head_id) < NMVU);
   assign w_cur_id        = r_paddr[APB_ADDR_WIDTH-1:12];
   assign w_cur_is_cmd    = (r_paddr[11:0] == CMD_CSR_ADDR);

   // Eligibility looks at busy as it will be after this edge, so a COMMAND
   // write completing now already blocks a following write to the same MVU.
   always_comb begin
      w_busy_set  = '0;
      w_head_busy = 1'b0;
      for (int i = 0; i < NMVU; i++) begin
         if (w_done && w_cur_is_cmd && (32'(w_cur_id) == 32'(i))) w_busy_set[i] = 1'b1;
      end
      w_busy_nxt = (r_busy & ~mvu_irq) | w_busy_set;
      for (int i = 0; i < NMVU; i++) begin
         if (32'(w_head_id) == 32'(i)) w_head_busy = w_busy_nxt[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               if (!w_head_in_range) begin
                  w_drop = 1'b1;
               end else if (!w_head_busy) begin
                  w_launch    = 1'b1;
                  w_state_nxt = S_SETUP;
               end
            end
         end
         S_SETUP: w_state_nxt = S_ACCESS;
         S_ACCESS: begin
            if (apb.pready) begin
               if (!w_empty && w_head_in_range && !w_head_busy) begin
                  w_launch    = 1'b1;
                  w_state_nxt = S_SETUP;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      apb.psel       = r_state[0];
      apb.penable    = r_state[1];
      apb.pwrite     = r_state[0];
      apb.paddr      = r_paddr;
      apb.pwdata     = r_pwdata;
      cmd.cmd_ready  = w_ready;
      mvu_busy       = r_busy;
      fifo_count     = r_count;
      err            = r_err;
      o_dbg_state    = r_state;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_id[r_wptr]   <= cmd.cmd_mvu_id;
         r_fifo_addr[r_wptr] <= cmd.cmd_addr;
         r_fifo_data[r_wptr] <= cmd.cmd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_paddr  <= '0;
         r_pwdata <= '0;
         r_busy   <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_launch) begin
            r_paddr  <= APB_ADDR_WIDTH'({w_head_id, w_head_addr});
            r_pwdata <= w_head_data;
         end
         r_busy <= w_busy_nxt;
         if (w_drop || (w_done && apb.pslverr)) r_err <= 1'b1;
         else if (err_clr)                      r_err <= 1'b0;
      end
   end

endmodule

// File: doc/mvu_apb_cfg_sequencer.md
Name: mvu_apb_cfg_sequencer

Overview:
- APB master that drains a queue of MVU CSR-write commands and issues them to the MVU array's APB configuration port, one transaction at a time and in order.
- Tracks a per-MVU busy flag: set when a write to the COMMAND CSR completes, cleared by that MVU's done interrupt.
- Holds back any further write to a busy MVU, so a running job is never reconfigured mid-flight.
- Sits between the controlling processor / command stream and the MVU array's APB slave.

Parameters:
NMVU, 8, number of MVUs addressed
BMVUA, 3, MVU index width (paddr[APB_ADDR_WIDTH-1:12])
APB_ADDR_WIDTH, 15, APB address width = BMVUA + 12
APB_DATA_WIDTH, 32, APB write data width
FIFO_DEPTH, 8, command FIFO entries (power of two, >= 2)
CMD_CSR_ADDR, 12'hF20, 12-bit CSR offset whose write launches an MVU job

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (= not full)
cmd_mvu_id  in  BMVUA  target MVU
cmd_addr  in  12  CSR offset
cmd_data  in  APB_DATA_WIDTH  write data
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB write (1 whenever psel)
paddr  out  APB_ADDR_WIDTH  {mvu_id, csr offset}
pwdata  out  APB_DATA_WIDTH  write data
pready  in  1  APB ready
pslverr  in  1  APB slave error
mvu_irq  in  NMVU  one-cycle done pulse per MVU
mvu_busy  out  NMVU  per-MVU job-in-flight flag
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
err  out  1  sticky error
err_clr  in  1  clears err

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. FIFO is empty, busy is cleared, FSM returns to IDLE. Reset mid-transaction abandons the transfer; psel/penable are low the cycle after reset is asserted.
- FIFO: a push occurs when cmd_valid && cmd_ready. cmd_ready = (fifo_count != FIFO_DEPTH). Push while full is impossible. Push and pop in the same cycle leave the count unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE -> SETUP when the FIFO is non-empty and the head is eligible. The head is popped on that edge and latched into paddr/pwdata.
  - Eligible: head mvu_id < NMVU and mvu_busy[mvu_id]=0.
  - Head with mvu_id >= NMVU: popped in IDLE without an APB transfer, err set, FSM stays IDLE.
  - Ineligible head (target busy): head-of-line blocks; no reordering.
- SETUP: psel=1, penable=0. Always advances to ACCESS after one cycle.
- ACCESS: psel=1, penable=1, held until pready=1. On the completing edge:
  - If pslverr=1, err is set.
  - If the offset == CMD_CSR_ADDR, mvu_busy[id] is set. It is set even when pslverr=1.
  - If the next head is eligible, go directly to SETUP (pop on this edge); otherwise go to IDLE.
- Latency: push on edge E0 -> psel high after E1 -> penable high after E2 -> completes at E3 if pready is already high. Back-to-back throughput is 2 cycles per write.
- Busy eligibility is evaluated with the mvu_busy value updated on the same edge. A COMMAND write followed by a write to the same MVU therefore stalls.
- mvu_irq[i] clears mvu_busy[i]. An irq for a non-busy MVU is ignored.
- If set and clear of the same bit coincide on one edge, set wins.
- err: set wins over err_clr when both occur on the same edge.
- Writes to a busy MVU's non-COMMAND CSRs are also held.

Test Plan:
- Single write: push {id=2, addr=12'h004, data=32'hDEAD_BEEF}, pready=1 -> psel high cycles 2-3, penable cycle 3, paddr=15'h2004, pwdata=DEADBEEF; fifo_count back to 0; mvu_busy=0.
- Job launch and stall: push COMMAND to MVU1, then a write to MVU1 offset 12'h010, then a write to MVU3 -> mvu_busy[1]=1 after the first transfer. The MVU1 write waits, and the MVU3 write is also blocked behind it (in order). Pulse mvu_irq[1] -> busy clears; both writes go out, 2 cycles apart.
- Wait states: pready low for 3 cycles in ACCESS -> psel/penable/paddr stable for 4 ACCESS cycles; next SETUP starts immediately after completion.
- Full FIFO: with MVU0 busy, push 8 commands to MVU0 -> cmd_ready=0 and fifo_count=8. A 9th cmd_valid is not accepted. irq[0] -> drains in order; cmd_ready=1 after the first pop.
- Errors: pslverr=1 on a transfer -> err=1 and busy semantics unchanged. Push with mvu_id >= NMVU (use NMVU=6) -> dropped with no psel and err=1. err_clr and a new error on the same edge -> err stays 1.
- Reset mid-ACCESS with 3 entries queued -> next cycle psel=0, fifo_count=0, mvu_busy=0, cmd_ready=1.
